// File: rtl/dcache_req_pkg.sv
// Shared types and constants for the dcache request master: size codes,
// FSM state encoding and the bus request record.
package dcache_req_pkg;

  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DROP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/dcache_wdata_align.sv
// Replicates right-aligned store data across the byte lanes so the slave can
// pick the lane from size and addr[1:0].
module dcache_wdata_align
  import dcache_req_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] wdata_rep
);

  always_comb begin
    case (size)
      SIZE_BYTE: wdata_rep = {4{wdata[7:0]}};
      SIZE_HALF: wdata_rep = {2{wdata[15:0]}};
      SIZE_WORD: wdata_rep = wdata;
      default:   wdata_rep = wdata;
    endcase
  end

endmodule

// File: rtl/dcache_req.sv
// Data-memory request master: one outstanding SRAM-like access at a time,
// stall request while busy, load word held while the next stage is stalled.
module dcache_req
  import dcache_req_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_excpt,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] rdata,
  output logic        stallreq
);

  state_t      state;
  bus_req_t    req_q;
  bus_req_t    live_req;
  bus_req_t    bus_req;
  logic [31:0] rbuf;
  logic [31:0] wdata_rep;
  logic        issue;

  assign issue    = mem_valid & ~mem_excpt & ~flush;
  assign live_req = '{we: mem_we, size: mem_size, addr: mem_addr, wdata: mem_wdata};
  // Outside IDLE the bus must show the copy taken when the request left IDLE
  assign bus_req  = (state == S_IDLE) ? live_req : req_q;

  dcache_wdata_align u_align (
    .size      (bus_req.size),
    .wdata     (bus_req.wdata),
    .wdata_rep (wdata_rep)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state <= S_IDLE;
      req_q <= '0;
      rbuf  <= ZERO_WORD;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            req_q <= live_req;
            state <= data_addr_ok ? S_WAIT : S_REQ;
          end
        end
        S_REQ: begin
          if (data_addr_ok)
            state <= flush ? S_DROP : S_WAIT;
          else if (flush)
            state <= S_IDLE;
        end
        S_WAIT: begin
          // A response landing together with flush belongs to a killed instruction
          if (flush) begin
            state <= data_data_ok ? S_IDLE : S_DROP;
          end else if (data_data_ok) begin
            rbuf  <= data_rdata;
            state <= hold ? S_DONE : S_IDLE;
          end
        end
        S_DONE: begin
          if (!hold || flush)
            state <= S_IDLE;
        end
        S_DROP: begin
          if (data_data_ok)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'b00;
    data_addr  = ZERO_WORD;
    data_wdata = ZERO_WORD;
    rdata      = ZERO_WORD;
    stallreq   = 1'b0;
    if (rst != RST_ENABLE) begin
      data_wr    = bus_req.we;
      data_size  = bus_req.size;
      data_addr  = bus_req.addr;
      data_wdata = wdata_rep;
      case (state)
        S_IDLE: begin
          data_req = issue;
          stallreq = issue;
        end
        S_REQ: begin
          data_req = 1'b1;
          stallreq = 1'b1;
        end
        S_WAIT: begin
          stallreq = ~data_data_ok;
          if (data_data_ok)
            rdata = data_rdata;
        end
        S_DONE: rdata = rbuf;
        S_DROP: stallreq = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_req.sv
// Self-checking bench for dcache_req: directed vector table, multi-cycle
// handshake sequences and a randomized run against a transaction-level model.
module tb_dcache_req;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, hold, mem_valid, mem_we, mem_excpt;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata, rdata;
  logic        stallreq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_req dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .hold         (hold),
    .mem_valid    (mem_valid),
    .mem_we       (mem_we),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_excpt    (mem_excpt),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .rdata        (rdata),
    .stallreq     (stallreq)
  );

  typedef struct {
    string       name;
    logic        v, we;
    logic [1:0]  sz;
    logic [31:0] addr, wdata;
    logic        excpt, fl;
    logic        exp_req;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[7];

  // Transaction-level model state
  bit          m_pend, m_acc, m_disc, m_hold;
  logic [31:0] m_held;
  logic        s_we;
  logic [1:0]  s_sz;
  logic [31:0] s_addr, s_wdata;

  function automatic logic [31:0] lanes(input logic [1:0] sz, input logic [31:0] w);
    logic [31:0] r;
    r = w;
    if (sz == 2'd0)
      for (int i = 0; i < 4; i++) r[8*i +: 8] = w[7:0];
    else if (sz == 2'd1)
      for (int i = 0; i < 2; i++) r[16*i +: 16] = w[15:0];
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic we, input logic [1:0] sz,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic ex, input logic fl, input logic hd,
                               input logic aok, input logic dok, input logic [31:0] rd);
    mem_valid = v;  mem_we = we;  mem_size = sz;  mem_addr = addr;  mem_wdata = wd;
    mem_excpt = ex; flush = fl;   hold = hd;
    data_addr_ok = aok; data_data_ok = dok; data_rdata = rd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic toNeg();
    @(negedge clk);
  endtask

  task automatic toNext();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int req_cnt, stall_cnt;
    logic v, we, ex, fl, hd, aok, dok, er, est, ewe;
    logic [1:0] sz, esz;
    logic [31:0] addr, wd, rd, erd, eaddr, ewd;

    vecs[0] = '{"byte store",  1, 1, 2'd0, 32'h0000_1003, 32'h0000_00A5, 0, 0, 1, 32'hA5A5_A5A5};
    vecs[1] = '{"half store",  1, 1, 2'd1, 32'h0000_2002, 32'h1234_ABCD, 0, 0, 1, 32'hABCD_ABCD};
    vecs[2] = '{"word store",  1, 1, 2'd2, 32'h0000_3000, 32'hCAFE_F00D, 0, 0, 1, 32'hCAFE_F00D};
    vecs[3] = '{"word load",   1, 0, 2'd2, 32'h8000_0010, 32'h0000_0000, 0, 0, 1, 32'h0000_0000};
    vecs[4] = '{"excpt store", 1, 1, 2'd0, 32'h0000_1003, 32'h0000_0011, 1, 0, 0, 32'h1111_1111};
    vecs[5] = '{"flush load",  1, 0, 2'd1, 32'h0000_4000, 32'h0000_5566, 0, 1, 0, 32'h5566_5566};
    vecs[6] = '{"no valid",    0, 1, 2'd2, 32'h0000_5000, 32'h7777_0000, 0, 0, 0, 32'h7777_0000};

    rst = 1'b1;
    idleInputs();
    toNext();
    toNeg();
    checkOutput("reset data_req", {31'b0, data_req}, 32'h0);
    checkOutput("reset stallreq", {31'b0, stallreq}, 32'h0);
    checkOutput("reset rdata", rdata, 32'h0);
    toNext();
    rst = 1'b0;
    toNext();

    // Directed vectors issued from IDLE; a flush cycle afterwards returns to IDLE
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].v, vecs[i].we, vecs[i].sz, vecs[i].addr, vecs[i].wdata,
                    vecs[i].excpt, vecs[i].fl, 0, 0, 0, 32'h0);
      toNeg();
      checkOutput({vecs[i].name, " data_req"}, {31'b0, data_req}, {31'b0, vecs[i].exp_req});
      checkOutput({vecs[i].name, " stallreq"}, {31'b0, stallreq}, {31'b0, vecs[i].exp_req});
      checkOutput({vecs[i].name, " data_size"}, {30'b0, data_size}, {30'b0, vecs[i].sz});
      checkOutput({vecs[i].name, " data_wdata"}, data_wdata, vecs[i].exp_wdata);
      checkOutput({vecs[i].name, " data_addr"}, data_addr, vecs[i].addr);
      checkOutput({vecs[i].name, " data_wr"}, {31'b0, data_wr}, {31'b0, vecs[i].we});
      toNext();
      applyStimulus(0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 32'h0);
      toNeg();
      checkOutput({vecs[i].name, " req held"}, {31'b0, data_req}, {31'b0, vecs[i].exp_req});
      toNext();
      idleInputs();
      toNeg();
      checkOutput({vecs[i].name, " back idle"}, {31'b0, stallreq}, 32'h0);
      toNext();
    end

    // Fast slave load
    applyStimulus(1, 0, 2'd2, 32'h0000_0100, 32'h0, 0, 0, 0, 1, 0, 32'h0);
    toNeg();
    checkOutput("fast req", {31'b0, data_req}, 32'h1);
    checkOutput("fast stall c0", {31'b0, stallreq}, 32'h1);
    toNext();
    applyStimulus(0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h1234_5678);
    toNeg();
    checkOutput("fast stall c1", {31'b0, stallreq}, 32'h0);
    checkOutput("fast rdata", rdata, 32'h1234_5678);
    toNext();
    idleInputs();
    toNeg();
    checkOutput("fast idle rdata", rdata, 32'h0);
    toNext();

    // Slow slave: addr_ok in cycle 3, data_ok in cycle 5
    req_cnt = 0;
    stall_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      if (c == 0)
        applyStimulus(1, 0, 2'd2, 32'h0000_2000, 32'h0, 0, 0, 0, 0, 0, 32'h0);
      else
        applyStimulus(0, 1, 2'd1, 32'hFFFF_FFF0, 32'h9999_9999, 0, 0, 0,
                      c == 3, c == 5, 32'h55AA_33CC);
      toNeg();
      if (data_req) begin
        req_cnt++;
        checkOutput("slow addr stable", data_addr, 32'h0000_2000);
      end
      if (stallreq) stall_cnt++;
      if (c == 5) checkOutput("slow rdata", rdata, 32'h55AA_33CC);
      toNext();
    end
    checkOutput("slow req cycles", req_cnt, 4);
    checkOutput("slow stall cycles", stall_cnt, 5);

    // Hold after data: word must stay presented while hold is high
    applyStimulus(1, 0, 2'd2, 32'h0000_0200, 32'h0, 0, 0, 0, 1, 0, 32'h0);
    toNext();
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(0, 0, 2'd0, 32'h0, 32'h0, 0, 0, c <= 4, 0, c == 1,
                    (c == 1) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD);
      toNeg();
      checkOutput($sformatf("hold rdata c%0d", c), rdata, (c <= 5) ? 32'hDEAD_BEEF : 32'h0);
      checkOutput($sformatf("hold stall c%0d", c), {31'b0, stallreq}, 32'h0);
      toNext();
    end

    // Flush in WAIT: response is dropped and no new request until IDLE
    applyStimulus(1, 0, 2'd2, 32'h0000_0300, 32'h0, 0, 0, 0, 1, 0, 32'h0);
    toNext();
    applyStimulus(0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 32'h0);
    toNeg();
    checkOutput("wflush stall", {31'b0, stallreq}, 32'h1);
    toNext();
    applyStimulus(1, 0, 2'd2, 32'h0000_0400, 32'h0, 0, 0, 0, 1, 0, 32'h0);
    toNeg();
    checkOutput("drop no req", {31'b0, data_req}, 32'h0);
    checkOutput("drop stall", {31'b0, stallreq}, 32'h1);
    toNext();
    applyStimulus(1, 0, 2'd2, 32'h0000_0400, 32'h0, 0, 0, 0, 0, 1, 32'h7654_3210);
    toNeg();
    checkOutput("drop discard", rdata, 32'h0);
    checkOutput("drop no req2", {31'b0, data_req}, 32'h0);
    toNext();
    applyStimulus(1, 0, 2'd2, 32'h0000_0400, 32'h0, 0, 0, 0, 1, 0, 32'h0);
    toNeg();
    checkOutput("after drop req", {31'b0, data_req}, 32'h1);
    toNext();
    applyStimulus(0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h0);
    toNext();

    // Flush in REQ before addr_ok
    applyStimulus(1, 1, 2'd2, 32'h0000_0500, 32'h1, 0, 0, 0, 0, 0, 32'h0);
    toNext();
    applyStimulus(0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 32'h0);
    toNeg();
    checkOutput("rflush req still", {31'b0, data_req}, 32'h1);
    toNext();
    idleInputs();
    toNeg();
    checkOutput("rflush req gone", {31'b0, data_req}, 32'h0);
    checkOutput("rflush stall", {31'b0, stallreq}, 32'h0);
    toNext();

    // Randomized run against the transaction-level model
    m_pend = 0; m_acc = 0; m_disc = 0; m_hold = 0; m_held = '0;
    s_we = 0; s_sz = '0; s_addr = '0; s_wdata = '0;
    for (int n = 0; n < 3000; n++) begin
      v    = ($urandom_range(0, 9) < 7);
      we   = $urandom_range(0, 1);
      sz   = 2'($urandom_range(0, 2));
      addr = $urandom;
      wd   = $urandom;
      ex   = ($urandom_range(0, 9) == 0);
      fl   = ($urandom_range(0, 9) == 0);
      hd   = ($urandom_range(0, 9) < 4);
      aok  = $urandom_range(0, 1);
      dok  = m_acc ? 1'($urandom_range(0, 1)) : 1'b0;
      rd   = $urandom;
      applyStimulus(v, we, sz, addr, wd, ex, fl, hd, aok, dok, rd);

      ewe = we; esz = sz; eaddr = addr; ewd = lanes(sz, wd);
      if (m_pend) begin
        er = 1; est = 1; erd = 0;
        ewe = s_we; esz = s_sz; eaddr = s_addr; ewd = lanes(s_sz, s_wdata);
      end else if (m_acc) begin
        er = 0; est = m_disc ? 1'b1 : !dok; erd = (!m_disc && dok) ? rd : 32'h0;
      end else if (m_hold) begin
        er = 0; est = 0; erd = m_held;
      end else begin
        er = v & ~ex & ~fl; est = er; erd = 0;
      end

      toNeg();
      checkOutput("rnd data_req", {31'b0, data_req}, {31'b0, er});
      checkOutput("rnd stallreq", {31'b0, stallreq}, {31'b0, est});
      checkOutput("rnd rdata", rdata, erd);
      if (er) begin
        checkOutput("rnd data_addr", data_addr, eaddr);
        checkOutput("rnd data_wr", {31'b0, data_wr}, {31'b0, ewe});
        checkOutput("rnd data_size", {30'b0, data_size}, {30'b0, esz});
        checkOutput("rnd data_wdata", data_wdata, ewd);
      end

      if (m_pend) begin
        if (aok) begin
          m_pend = 0; m_acc = 1; m_disc = fl;
        end else if (fl) begin
          m_pend = 0;
        end
      end else if (m_acc) begin
        if (dok) begin
          m_acc = 0;
          if (!m_disc && !fl && hd) begin
            m_hold = 1; m_held = rd;
          end
        end else if (fl) begin
          m_disc = 1;
        end
      end else if (m_hold) begin
        if (!hd || fl) m_hold = 0;
      end else if (er) begin
        if (aok) begin
          m_acc = 1; m_disc = 0;
        end else begin
          m_pend = 1; s_we = we; s_sz = sz; s_addr = addr; s_wdata = wd;
        end
      end
      toNext();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
